// File: rtl/decoder_seq_pkg.sv
// Shared definitions for the serial-decoder sequencer: state encoding and default geometry.
package decoder_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        WAIT   = 2'd2,
        REPORT = 2'd3
    } seq_state_t;

    localparam int DEF_WORD_W   = 4;
    localparam int DEF_RESP_WIN = 4;

endpackage : decoder_seq_pkg

// File: rtl/dec_shift_out.sv
// Load/shift register that presents a codeword MSB-first and flags when the final bit is on the line.
module dec_shift_out #(
    parameter int WORD_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic [WORD_W-1:0] i_word,
    output logic              o_bit,
    output logic              o_last
);

    localparam int BIT_CNT_W = $clog2(WORD_W);

    logic [WORD_W-1:0]    r_sreg;
    logic [BIT_CNT_W-1:0] r_bit_cnt;

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sreg    <= '0;
            r_bit_cnt <= '0;
        end else if (i_load) begin
            r_sreg    <= i_word;
            r_bit_cnt <= '0;
        end else if (i_shift) begin
            r_sreg <= {r_sreg[WORD_W-2:0], 1'b0};
            // Hold at the terminal count rather than wrapping.
            if (!o_last)
                r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
        end
    end

    assign o_bit  = r_sreg[WORD_W-1];
    assign o_last = (r_bit_cnt == BIT_CNT_W'(WORD_W - 1));

endmodule : dec_shift_out

// File: rtl/decoder_seq_ctrl.sv
// Sequencer feeding codewords serially to the decoder and reporting one hit/miss per word.
// Optional saturating hit counter enabled by defining HIT_COUNT_EN.
module decoder_seq_ctrl
    import decoder_seq_pkg::*;
#(
    parameter int WORD_W   = DEF_WORD_W,
    parameter int RESP_WIN = DEF_RESP_WIN
`ifdef HIT_COUNT_EN
    ,
    parameter int CNT_W    = 8
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              dec_x,
    input  logic              dec_z,
    output logic              res_valid,
    output logic              res_hit,
    output logic              busy
`ifdef HIT_COUNT_EN
    ,
    output logic [CNT_W-1:0]  hit_count
`endif
);

    localparam int WIN_W = (RESP_WIN > 1) ? $clog2(RESP_WIN) : 1;

    seq_state_t       r_state;
    seq_state_t       w_next;
    logic             r_hit;
    logic [WIN_W-1:0] r_win_cnt;
    logic             w_load;
    logic             w_shift;
    logic             w_bit;
    logic             w_last;
    logic             w_win_done;

    dec_shift_out #(
        .WORD_W (WORD_W)
    ) u_shift (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_word  (in_word),
        .o_bit   (w_bit),
        .o_last  (w_last)
    );

    assign w_win_done = (r_win_cnt == WIN_W'(RESP_WIN - 1));

    // NOTE: every signal driven here gets a default first, so no path can leave it
    // unassigned and infer a latch.
    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_shift = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_load = 1'b1;
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                w_shift = 1'b1;
                if (w_last)
                    w_next = WAIT;
            end
            WAIT: begin
                if (r_hit || dec_z || w_win_done)
                    w_next = REPORT;
            end
            REPORT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_hit     <= 1'b0;
            r_win_cnt <= '0;
        end else begin
            r_state <= w_next;

            // Sticky match flag: cleared at accept, set by any dec_z seen while the word is live.
            if (w_load)
                r_hit <= 1'b0;
            else if ((r_state == SHIFT || r_state == WAIT) && dec_z)
                r_hit <= 1'b1;

            if (r_state == SHIFT)
                r_win_cnt <= '0;
            else if (r_state == WAIT && !r_hit && !dec_z && !w_win_done)
                r_win_cnt <= r_win_cnt + WIN_W'(1);
        end
    end

`ifdef HIT_COUNT_EN
    logic [CNT_W-1:0] r_hit_count;

    always_ff @(posedge clk) begin
        if (reset)
            r_hit_count <= '0;
        else if (r_state == REPORT && r_hit && r_hit_count != '1)
            r_hit_count <= r_hit_count + CNT_W'(1);
    end

    assign hit_count = r_hit_count;
`endif

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign res_valid = (r_state == REPORT);
    assign res_hit   = (r_state == REPORT) && r_hit;
    // The decoder only ever sees live codeword bits; zero outside SHIFT.
    assign dec_x     = (r_state == SHIFT) && w_bit;

endmodule : decoder_seq_ctrl
